logic_axi4_stream_split_routed_top: RTL and testbench



---
 rtl/logic_axi4_stream_split_routed_top.sv | 183 ++++++++++++++++++
 tb/tb_logic_axi4_stream_split_routed_top.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_split_routed_top.sv
`default_nettype none
// ============================================================================
// Module   : logic_axi4_stream_split_routed_top
// Purpose  : Registered AXI4-Stream 1-to-N splitter. It can broadcast each
//            beat to every output (MODE=0) or route each beat by tdest
//            (MODE=1). Routing can be packet-atomic. A saturating counter
//            records beats dropped for an out-of-range destination.
// Ports    : aclk/areset         - clock, synchronous active-high reset
//            rx_*                - single AXI4-Stream slave
//            tx_*                - OUTPUTS flattened AXI4-Stream masters that
//                                  share one registered payload
//            drop_count          - beats discarded for invalid tdest
// Revision : 1.0 - initial release
// ============================================================================
module logic_axi4_stream_split_routed_top #(
  parameter int OUTPUTS     = 4,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 2,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TLAST   = 1'b1,
  parameter bit USE_TKEEP   = 1'b1,
  parameter bit USE_TSTRB   = 1'b1,
  parameter bit MODE        = 1'b0,
  parameter bit PACKET_LOCK = 1'b1
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               rx_tvalid,
  input  logic                               rx_tlast,
  input  logic [TDATA_BYTES*8-1:0]           rx_tdata,
  input  logic [TDATA_BYTES-1:0]             rx_tstrb,
  input  logic [TDATA_BYTES-1:0]             rx_tkeep,
  input  logic [TDEST_WIDTH-1:0]             rx_tdest,
  input  logic [TUSER_WIDTH-1:0]             rx_tuser,
  input  logic [TID_WIDTH-1:0]               rx_tid,
  output logic                               rx_tready,
  output logic [OUTPUTS-1:0]                 tx_tvalid,
  output logic [OUTPUTS-1:0]                 tx_tlast,
  output logic [OUTPUTS*TDATA_BYTES*8-1:0]   tx_tdata,
  output logic [OUTPUTS*TDATA_BYTES-1:0]     tx_tstrb,
  output logic [OUTPUTS*TDATA_BYTES-1:0]     tx_tkeep,
  output logic [OUTPUTS*TDEST_WIDTH-1:0]     tx_tdest,
  output logic [OUTPUTS*TUSER_WIDTH-1:0]     tx_tuser,
  output logic [OUTPUTS*TID_WIDTH-1:0]       tx_tid,
  input  logic [OUTPUTS-1:0]                 tx_tready,
  output logic [15:0]                        drop_count
);

  localparam int         c_data_w    = TDATA_BYTES * 8;
  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  // Holding register
  logic                    full_q, full_d;
  logic [OUTPUTS-1:0]      pending_q, pending_d;
  logic [c_data_w-1:0]     data_q;
  logic [TDATA_BYTES-1:0]  strb_q, keep_q;
  logic [TDEST_WIDTH-1:0]  dest_q;
  logic [TUSER_WIDTH-1:0]  user_q;
  logic [TID_WIDTH-1:0]    id_q;
  logic                    last_q;

  // Routing state and drop counter
  logic [0:0]              state_q, state_d;
  logic [TDEST_WIDTH-1:0]  dst_q, dst_d;
  logic [15:0]             drop_count_q, drop_count_d;

  logic                    w_last_eff;
  logic [TDATA_BYTES-1:0]  w_keep_eff, w_strb_eff;
  logic [TDEST_WIDTH-1:0]  w_sel;
  logic                    w_sel_oob;
  logic                    w_drop;
  logic                    w_rx_hs;
  logic                    w_load;
  logic                    w_release;
  logic                    w_rx_ready;
  logic [OUTPUTS-1:0]      w_tx_valid;
  logic [OUTPUTS-1:0]      w_tx_hs;
  logic [OUTPUTS-1:0]      w_onehot;

  // Optional sideband fields collapse to their AXI defaults when disabled.
  assign w_last_eff = USE_TLAST ? rx_tlast : 1'b1;
  assign w_keep_eff = USE_TKEEP ? rx_tkeep : {TDATA_BYTES{1'b1}};
  assign w_strb_eff = USE_TSTRB ? rx_tstrb : w_keep_eff;

  // Inside a locked packet the latched destination wins over the live tdest.
  assign w_sel     = (PACKET_LOCK && (state_q == c_st_locked)) ? dst_q : rx_tdest;
  assign w_sel_oob = (32'(w_sel) >= 32'(OUTPUTS));
  assign w_drop    = MODE && w_sel_oob;
  assign w_onehot  = {{(OUTPUTS-1){1'b0}}, 1'b1} << w_sel;

  // Valid is gated by reset so a held beat is never shown while resetting.
  assign w_tx_valid = {OUTPUTS{full_q & ~areset}} & pending_q;
  assign w_tx_hs    = w_tx_valid & tx_tready;
  assign w_release  = full_q && ((pending_q & ~w_tx_hs) == '0);
  assign w_rx_ready = ~areset & (~full_q | w_release);
  assign w_rx_hs    = rx_tvalid & w_rx_ready;
  assign w_load     = w_rx_hs & ~w_drop;

  always_comb begin
    full_d    = full_q & ~w_release;
    pending_d = pending_q & ~w_tx_hs;
    if (w_load) begin
      full_d    = 1'b1;
      pending_d = MODE ? w_onehot : {OUTPUTS{1'b1}};
    end
  end

  // Packet tracking runs on every accepted beat, dropped ones included, so a
  // packet to an invalid destination is discarded in its entirety.
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    if (w_rx_hs) begin
      if (state_q == c_st_idle) begin
        if (!w_last_eff) begin
          state_d = c_st_locked;
          dst_d   = rx_tdest;
        end
      end else if (w_last_eff) begin
        state_d = c_st_idle;
      end
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (w_rx_hs && w_drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q       <= 1'b0;
      pending_q    <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      keep_q       <= '0;
      dest_q       <= '0;
      user_q       <= '0;
      id_q         <= '0;
      last_q       <= 1'b0;
      state_q      <= c_st_idle;
      dst_q        <= '0;
      drop_count_q <= '0;
    end else begin
      full_q       <= full_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      dst_q        <= dst_d;
      drop_count_q <= drop_count_d;
      if (w_load) begin
        data_q <= rx_tdata;
        strb_q <= w_strb_eff;
        keep_q <= w_keep_eff;
        dest_q <= rx_tdest;
        user_q <= rx_tuser;
        id_q   <= rx_tid;
        last_q <= w_last_eff;
      end
    end
  end

  assign rx_tready  = w_rx_ready;
  assign tx_tvalid  = w_tx_valid;
  assign drop_count = drop_count_q;

  generate
    for (genvar k = 0; k < OUTPUTS; k++) begin : g_tx
      assign tx_tlast[k]                               = last_q;
      assign tx_tdata[k*c_data_w +: c_data_w]          = data_q;
      assign tx_tstrb[k*TDATA_BYTES +: TDATA_BYTES]    = strb_q;
      assign tx_tkeep[k*TDATA_BYTES +: TDATA_BYTES]    = keep_q;
      assign tx_tdest[k*TDEST_WIDTH +: TDEST_WIDTH]    = dest_q;
      assign tx_tuser[k*TUSER_WIDTH +: TUSER_WIDTH]    = user_q;
      assign tx_tid[k*TID_WIDTH +: TID_WIDTH]          = id_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_stream_split_routed_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_axi4_stream_split_routed_top
// Purpose  : Self-checking bench. Instance bc broadcasts to 4 outputs,
//            instance rt routes by tdest to 3 outputs with packet lock.
//            Expected beats are queued per output as stimulus is driven and
//            matched against beats captured on each tx handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_axi4_stream_split_routed_top;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int compared = 0;
  int mismatched = 0;

  // Broadcast instance signals
  logic        bc_rx_tvalid, bc_rx_tlast, bc_rx_tready;
  logic [31:0] bc_rx_tdata;
  logic [3:0]  bc_rx_tstrb, bc_rx_tkeep;
  logic [1:0]  bc_rx_tdest;
  logic [0:0]  bc_rx_tuser, bc_rx_tid;
  logic [3:0]  bc_tx_tvalid, bc_tx_tlast, bc_tx_tready, bc_tx_tuser, bc_tx_tid;
  logic [127:0] bc_tx_tdata;
  logic [15:0] bc_tx_tstrb, bc_tx_tkeep, bc_drop;
  logic [7:0]  bc_tx_tdest;

  // Routed instance signals
  logic        rt_rx_tvalid, rt_rx_tlast, rt_rx_tready;
  logic [31:0] rt_rx_tdata;
  logic [3:0]  rt_rx_tstrb, rt_rx_tkeep;
  logic [1:0]  rt_rx_tdest;
  logic [0:0]  rt_rx_tuser, rt_rx_tid;
  logic [2:0]  rt_tx_tvalid, rt_tx_tlast, rt_tx_tready, rt_tx_tuser, rt_tx_tid;
  logic [95:0] rt_tx_tdata;
  logic [11:0] rt_tx_tstrb, rt_tx_tkeep;
  logic [5:0]  rt_tx_tdest;
  logic [15:0] rt_drop;

  logic [31:0] bc_exp [4][$];
  logic [31:0] bc_obs [4][$];
  logic [34:0] rt_exp [3][$];
  logic [34:0] rt_obs [3][$];

  logic_axi4_stream_split_routed_top #(
    .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TLAST(1'b1), .USE_TKEEP(1'b1), .USE_TSTRB(1'b1), .MODE(1'b0), .PACKET_LOCK(1'b1)
  ) u_bc (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(bc_rx_tvalid), .rx_tlast(bc_rx_tlast), .rx_tdata(bc_rx_tdata),
    .rx_tstrb(bc_rx_tstrb), .rx_tkeep(bc_rx_tkeep), .rx_tdest(bc_rx_tdest),
    .rx_tuser(bc_rx_tuser), .rx_tid(bc_rx_tid), .rx_tready(bc_rx_tready),
    .tx_tvalid(bc_tx_tvalid), .tx_tlast(bc_tx_tlast), .tx_tdata(bc_tx_tdata),
    .tx_tstrb(bc_tx_tstrb), .tx_tkeep(bc_tx_tkeep), .tx_tdest(bc_tx_tdest),
    .tx_tuser(bc_tx_tuser), .tx_tid(bc_tx_tid), .tx_tready(bc_tx_tready),
    .drop_count(bc_drop)
  );

  logic_axi4_stream_split_routed_top #(
    .OUTPUTS(3), .TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TLAST(1'b1), .USE_TKEEP(1'b1), .USE_TSTRB(1'b1), .MODE(1'b1), .PACKET_LOCK(1'b1)
  ) u_rt (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(rt_rx_tvalid), .rx_tlast(rt_rx_tlast), .rx_tdata(rt_rx_tdata),
    .rx_tstrb(rt_rx_tstrb), .rx_tkeep(rt_rx_tkeep), .rx_tdest(rt_rx_tdest),
    .rx_tuser(rt_rx_tuser), .rx_tid(rt_rx_tid), .rx_tready(rt_rx_tready),
    .tx_tvalid(rt_tx_tvalid), .tx_tlast(rt_tx_tlast), .tx_tdata(rt_tx_tdata),
    .tx_tstrb(rt_tx_tstrb), .tx_tkeep(rt_tx_tkeep), .tx_tdest(rt_tx_tdest),
    .tx_tuser(rt_tx_tuser), .tx_tid(rt_tx_tid), .tx_tready(rt_tx_tready),
    .drop_count(rt_drop)
  );

  // Capture every output handshake; it completes at the following rising edge.
  always @(negedge aclk) begin
    for (int k = 0; k < 4; k++)
      if (bc_tx_tvalid[k] && bc_tx_tready[k]) bc_obs[k].push_back(bc_tx_tdata[k*32 +: 32]);
    for (int k = 0; k < 3; k++)
      if (rt_tx_tvalid[k] && rt_tx_tready[k])
        rt_obs[k].push_back({rt_tx_tlast[k], rt_tx_tdest[k*2 +: 2], rt_tx_tdata[k*32 +: 32]});
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] o, e;
    logic [34:0] ro, re;
    areset = 1'b1;
    bc_rx_tvalid = 1'b1; bc_rx_tdata = 32'hDEAD_0001; bc_tx_tready = 4'hF;
    rt_rx_tvalid = 1'b1; rt_rx_tdata = 32'hDEAD_0002; rt_rx_tdest = 2'd0; rt_rx_tlast = 1'b1;
    rt_tx_tready = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      compared++;
      if (bc_rx_tready !== 1'b0 || rt_rx_tready !== 1'b0) begin
        mismatched++; $display("FAIL reset_rx_tready c=%0d: got bc=%b rt=%b want 0", c, bc_rx_tready, rt_rx_tready);
      end
      compared++;
      if (bc_tx_tvalid !== 4'h0 || rt_tx_tvalid !== 3'h0) begin
        mismatched++; $display("FAIL reset_tx_tvalid c=%0d: got bc=%h rt=%h want 0", c, bc_tx_tvalid, rt_tx_tvalid);
      end
      if (c > 0) begin
        compared++;
        if (bc_drop !== 16'h0 || rt_drop !== 16'h0 || bc_tx_tdata !== '0 || rt_tx_tdata !== '0 || bc_tx_tlast !== '0) begin
          mismatched++; $display("FAIL reset_values c=%0d: got drop=%h/%h data0=%h want all 0", c, bc_drop, rt_drop, bc_tx_tdata[31:0]);
        end
      end
      tick();
    end
    areset = 1'b0;
    for (int k = 0; k < 4; k++) bc_exp[k].push_back(32'hDEAD_0001);
    rt_exp[0].push_back({1'b1, 2'd0, 32'hDEAD_0002});
    @(negedge aclk);
    compared++;
    if (bc_rx_tready !== 1'b1 || rt_rx_tready !== 1'b1) begin
      mismatched++; $display("FAIL post_reset_rx_tready: got bc=%b rt=%b want 1", bc_rx_tready, rt_rx_tready);
    end
    tick();
    bc_rx_tvalid = 1'b0; rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (bc_tx_tvalid !== 4'hF || bc_tx_tdata[31:0] !== 32'hDEAD_0001 || rt_tx_tvalid !== 3'b001) begin
      mismatched++; $display("FAIL first_beat_latency: got bc=%h data=%h rt=%b want F DEAD0001 001", bc_tx_tvalid, bc_tx_tdata[31:0], rt_tx_tvalid);
    end
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bc_obs[k].size() != bc_exp[k].size()) begin
        mismatched++; $display("FAIL reset_bc_count[%0d]: got %0d want %0d", k, bc_obs[k].size(), bc_exp[k].size());
      end
      while (bc_obs[k].size() > 0 && bc_exp[k].size() > 0) begin
        o = bc_obs[k].pop_front(); e = bc_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL reset_bc_data[%0d]: got %h want %h", k, o, e); end
      end
      bc_obs[k].delete(); bc_exp[k].delete();
    end
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (rt_obs[k].size() != rt_exp[k].size()) begin
        mismatched++; $display("FAIL reset_rt_count[%0d]: got %0d want %0d", k, rt_obs[k].size(), rt_exp[k].size());
      end
      while (rt_obs[k].size() > 0 && rt_exp[k].size() > 0) begin
        ro = rt_obs[k].pop_front(); re = rt_exp[k].pop_front(); compared++;
        if (ro !== re) begin mismatched++; $display("FAIL reset_rt_beat[%0d]: got %h want %h", k, ro, re); end
      end
      rt_obs[k].delete(); rt_exp[k].delete();
    end
  endtask

  task automatic test_broadcast_stagger();
    logic [3:0] exp_v [9];
    logic       exp_r [9];
    logic [31:0] o, e;
    exp_v = '{4'h0, 4'hF, 4'hE, 4'hE, 4'h8, 4'h8, 4'h8, 4'hF, 4'h0};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 9; c++) begin
      bc_rx_tvalid = (c <= 6);
      bc_rx_tdata  = (c == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      bc_tx_tready = {(c >= 6), (c >= 3), (c >= 3), (c >= 1)};
      if (c == 0) for (int k = 0; k < 4; k++) bc_exp[k].push_back(32'hA5A5_A5A5);
      if (c == 6) for (int k = 0; k < 4; k++) bc_exp[k].push_back(32'h5A5A_5A5A);
      @(negedge aclk);
      compared++;
      if (bc_tx_tvalid !== exp_v[c]) begin
        mismatched++; $display("FAIL stagger_tvalid c=%0d: got %h want %h", c, bc_tx_tvalid, exp_v[c]);
      end
      compared++;
      if (bc_rx_tready !== exp_r[c]) begin
        mismatched++; $display("FAIL stagger_rx_tready c=%0d: got %b want %b", c, bc_rx_tready, exp_r[c]);
      end
      tick();
    end
    bc_rx_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bc_obs[k].size() != bc_exp[k].size()) begin
        mismatched++; $display("FAIL stagger_count[%0d]: got %0d want %0d", k, bc_obs[k].size(), bc_exp[k].size());
      end
      while (bc_obs[k].size() > 0 && bc_exp[k].size() > 0) begin
        o = bc_obs[k].pop_front(); e = bc_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL stagger_data[%0d]: got %h want %h", k, o, e); end
      end
      bc_obs[k].delete(); bc_exp[k].delete();
    end
  endtask

  task automatic test_full_throughput();
    int stalls = 0;
    int vcnt = 0;
    int last_c = -1;
    logic [31:0] o, e;
    bc_tx_tready = 4'hF;
    for (int c = 0; c < 102; c++) begin
      bc_rx_tvalid = (c < 100);
      bc_rx_tdata  = 32'h1000_0000 + 32'(c);
      if (c < 100) for (int k = 0; k < 4; k++) bc_exp[k].push_back(32'h1000_0000 + 32'(c));
      @(negedge aclk);
      if (c < 100 && !bc_rx_tready) stalls++;
      if (bc_tx_tvalid == 4'hF) begin vcnt++; last_c = c; end
      tick();
    end
    bc_rx_tvalid = 1'b0;
    compared++;
    if (stalls != 0) begin mismatched++; $display("FAIL thru_stalls: got %0d want 0", stalls); end
    compared++;
    if (vcnt != 100) begin mismatched++; $display("FAIL thru_valid_cycles: got %0d want 100", vcnt); end
    compared++;
    if (last_c != 100) begin mismatched++; $display("FAIL thru_last_cycle: got %0d want 100", last_c); end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bc_obs[k].size() != bc_exp[k].size()) begin
        mismatched++; $display("FAIL thru_count[%0d]: got %0d want %0d", k, bc_obs[k].size(), bc_exp[k].size());
      end
      while (bc_obs[k].size() > 0 && bc_exp[k].size() > 0) begin
        o = bc_obs[k].pop_front(); e = bc_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL thru_data[%0d]: got %h want %h", k, o, e); end
      end
      bc_obs[k].delete(); bc_exp[k].delete();
    end
  endtask

  task automatic test_packet_lock();
    logic [1:0] dests [6];
    logic       lasts [6];
    logic [34:0] o, e;
    dests = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd0};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rt_tx_tready = 3'b111;
    for (int c = 0; c < 6; c++) begin
      rt_rx_tvalid = 1'b1;
      rt_rx_tdata  = 32'hC0DE_0000 + 32'(c);
      rt_rx_tdest  = dests[c];
      rt_rx_tlast  = lasts[c];
      if (c < 4) rt_exp[2].push_back({lasts[c], dests[c], 32'hC0DE_0000 + 32'(c)});
      else       rt_exp[1].push_back({lasts[c], dests[c], 32'hC0DE_0000 + 32'(c)});
      @(negedge aclk);
      compared++;
      if (rt_rx_tready !== 1'b1) begin mismatched++; $display("FAIL lock_rx_tready c=%0d: got %b want 1", c, rt_rx_tready); end
      tick();
    end
    rt_rx_tvalid = 1'b0;
    tick(); tick();
    compared++;
    if (rt_drop !== 16'h0) begin mismatched++; $display("FAIL lock_drop_count: got %h want 0", rt_drop); end
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (rt_obs[k].size() != rt_exp[k].size()) begin
        mismatched++; $display("FAIL lock_count[%0d]: got %0d want %0d", k, rt_obs[k].size(), rt_exp[k].size());
      end
      while (rt_obs[k].size() > 0 && rt_exp[k].size() > 0) begin
        o = rt_obs[k].pop_front(); e = rt_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL lock_beat[%0d]: got %h want %h", k, o, e); end
      end
      rt_obs[k].delete(); rt_exp[k].delete();
    end
  endtask

  task automatic test_drop();
    logic [34:0] o, e;
    rt_tx_tready = 3'b111;
    for (int c = 0; c < 5; c++) begin
      rt_rx_tvalid = 1'b1; rt_rx_tdest = 2'd3; rt_rx_tlast = (c == 4);
      rt_rx_tdata = 32'hBAD0_0000 + 32'(c);
      @(negedge aclk);
      compared++;
      if (rt_rx_tready !== 1'b1 || rt_tx_tvalid !== 3'b000) begin
        mismatched++; $display("FAIL drop_handshake c=%0d: got ready=%b tvalid=%b want 1 000", c, rt_rx_tready, rt_tx_tvalid);
      end
      tick();
    end
    rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (rt_drop !== 16'd5 || rt_tx_tvalid !== 3'b000) begin
      mismatched++; $display("FAIL drop_count_5: got %h tvalid=%b want 0005 000", rt_drop, rt_tx_tvalid);
    end
    tick();
    rt_rx_tvalid = 1'b1; rt_rx_tlast = 1'b1; rt_rx_tdest = 2'd3;
    repeat (65529) tick();
    rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (rt_drop !== 16'hFFFE) begin mismatched++; $display("FAIL drop_count_fffe: got %h want fffe", rt_drop); end
    tick();
    rt_rx_tvalid = 1'b1;
    tick();
    rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (rt_drop !== 16'hFFFF) begin mismatched++; $display("FAIL drop_count_ffff: got %h want ffff", rt_drop); end
    tick();
    rt_rx_tvalid = 1'b1;
    repeat (3) tick();
    rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (rt_drop !== 16'hFFFF) begin mismatched++; $display("FAIL drop_count_saturate: got %h want ffff", rt_drop); end
    tick();
    rt_rx_tvalid = 1'b1; rt_rx_tdest = 2'd0; rt_rx_tlast = 1'b1; rt_rx_tdata = 32'h600D_0000;
    rt_exp[0].push_back({1'b1, 2'd0, 32'h600D_0000});
    tick();
    rt_rx_tvalid = 1'b0;
    @(negedge aclk);
    compared++;
    if (rt_tx_tvalid !== 3'b001) begin mismatched++; $display("FAIL drop_then_valid: got %b want 001", rt_tx_tvalid); end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (rt_obs[k].size() != rt_exp[k].size()) begin
        mismatched++; $display("FAIL drop_out_count[%0d]: got %0d want %0d", k, rt_obs[k].size(), rt_exp[k].size());
      end
      while (rt_obs[k].size() > 0 && rt_exp[k].size() > 0) begin
        o = rt_obs[k].pop_front(); e = rt_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL drop_out_beat[%0d]: got %h want %h", k, o, e); end
      end
      rt_obs[k].delete(); rt_exp[k].delete();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [34:0] o, e;
    rt_tx_tready = 3'b111;
    rt_rx_tvalid = 1'b1; rt_rx_tdest = 2'd1; rt_rx_tlast = 1'b0; rt_rx_tdata = 32'h0111_0001;
    rt_exp[1].push_back({1'b0, 2'd1, 32'h0111_0001});
    tick();
    rt_rx_tdata = 32'h0111_0002;
    tick();
    // Second beat is held (output 1 stalled) when reset arrives.
    rt_rx_tvalid = 1'b0; rt_tx_tready = 3'b000; areset = 1'b1;
    @(negedge aclk);
    compared++;
    if (rt_tx_tvalid !== 3'b000 || rt_rx_tready !== 1'b0) begin
      mismatched++; $display("FAIL midrst_during: got tvalid=%b ready=%b want 000 0", rt_tx_tvalid, rt_rx_tready);
    end
    tick();
    areset = 1'b0; rt_tx_tready = 3'b111;
    rt_rx_tvalid = 1'b1; rt_rx_tdest = 2'd0; rt_rx_tlast = 1'b0; rt_rx_tdata = 32'h0222_0001;
    rt_exp[0].push_back({1'b0, 2'd0, 32'h0222_0001});
    @(negedge aclk);
    compared++;
    if (rt_drop !== 16'h0 || rt_rx_tready !== 1'b1 || rt_tx_tvalid !== 3'b000) begin
      mismatched++; $display("FAIL midrst_after: got drop=%h ready=%b tvalid=%b want 0000 1 000", rt_drop, rt_rx_tready, rt_tx_tvalid);
    end
    tick();
    rt_rx_tdest = 2'd2; rt_rx_tlast = 1'b1; rt_rx_tdata = 32'h0222_0002;
    rt_exp[0].push_back({1'b1, 2'd2, 32'h0222_0002});
    tick();
    rt_rx_tvalid = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (rt_obs[k].size() != rt_exp[k].size()) begin
        mismatched++; $display("FAIL midrst_count[%0d]: got %0d want %0d", k, rt_obs[k].size(), rt_exp[k].size());
      end
      while (rt_obs[k].size() > 0 && rt_exp[k].size() > 0) begin
        o = rt_obs[k].pop_front(); e = rt_exp[k].pop_front(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL midrst_beat[%0d]: got %h want %h", k, o, e); end
      end
      rt_obs[k].delete(); rt_exp[k].delete();
    end
  endtask

  initial begin
    bc_rx_tvalid = 1'b0; bc_rx_tlast = 1'b1; bc_rx_tdata = '0; bc_rx_tstrb = 4'hF;
    bc_rx_tkeep = 4'hF; bc_rx_tdest = '0; bc_rx_tuser = '0; bc_rx_tid = '0; bc_tx_tready = '0;
    rt_rx_tvalid = 1'b0; rt_rx_tlast = 1'b1; rt_rx_tdata = '0; rt_rx_tstrb = 4'hF;
    rt_rx_tkeep = 4'hF; rt_rx_tdest = '0; rt_rx_tuser = '0; rt_rx_tid = '0; rt_tx_tready = '0;
    test_reset();
    test_broadcast_stagger();
    test_full_throughput();
    test_packet_lock();
    test_drop();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
